// File: rtl/median_stream_ctrl.sv
// Median-filter stream controller: delays syncs and centre pixels, measures frame
// geometry, and picks raw/black/median per pixel. MEDIAN_CTRL_STATS_EN builds frame/error counters.
module median_stream_ctrl #(
    parameter int MED_LAT  = 4,
    parameter int SYNC_LAT = 6,
    parameter int BORDER   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_dv,
    input  logic        rx_hs,
    input  logic        rx_vs,
    input  logic [7:0]  ctr_red,
    input  logic [7:0]  ctr_green,
    input  logic [7:0]  ctr_blue,
    input  logic [7:0]  med_red,
    input  logic [7:0]  med_green,
    input  logic [7:0]  med_blue,
    input  logic        border_mode,
    input  logic        filt_en,
    output logic        tx_dv,
    output logic        tx_hs,
    output logic        tx_vs,
    output logic [7:0]  tx_red,
    output logic [7:0]  tx_green,
    output logic [7:0]  tx_blue,
    output logic        locked,
    output logic [11:0] h_active,
    output logic [11:0] v_active,
    output logic [15:0] frame_cnt,
    output logic [7:0]  err_cnt
);

    typedef enum logic [1:0] {IDLE, MEASURE, RUN} state_t;

    localparam logic [12:0] BORDER_W = 13'(BORDER);
    localparam logic [11:0] CNT_MAX  = 12'hFFF;

    // Reset asserts asynchronously, releases two clocks later.
    logic [1:0] rst_sync_reg;
    logic       rst_int_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_reg <= 2'b00;
        else        rst_sync_reg <= {rst_sync_reg[0], 1'b1};
    end
    assign rst_int_n = rst_sync_reg[1];

    // Sync pipeline, element i = {vs, hs, dv} after i+1 registers.
    logic [2:0] sync_pipe_reg [0:SYNC_LAT-1];

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            for (int i = 0; i < SYNC_LAT; i++) sync_pipe_reg[i] <= 3'b000;
        end else begin
            sync_pipe_reg[0] <= {rx_vs, rx_hs, rx_dv};
            for (int i = 1; i < SYNC_LAT; i++) sync_pipe_reg[i] <= sync_pipe_reg[i-1];
        end
    end
    assign {tx_vs, tx_hs, tx_dv} = sync_pipe_reg[SYNC_LAT-1];

    // The stage feeding the last register drives the registered pixel select.
    logic pre_dv, pre_vs;
    generate
        if (SYNC_LAT >= 2) begin : g_pre_pipe
            assign pre_dv = sync_pipe_reg[SYNC_LAT-2][0];
            assign pre_vs = sync_pipe_reg[SYNC_LAT-2][2];
        end else begin : g_pre_direct
            assign pre_dv = rx_dv;
            assign pre_vs = rx_vs;
        end
    endgenerate

    logic dv_fall, vs_rise;
    assign dv_fall = tx_dv & ~pre_dv;
    assign vs_rise = pre_vs & ~tx_vs;

    logic [23:0] ctr_d;
    generate
        if (MED_LAT >= 1) begin : g_ctr_dly
            logic [23:0] ctr_pipe_reg [0:MED_LAT-1];
            always_ff @(posedge clk or negedge rst_int_n) begin
                if (!rst_int_n) begin
                    for (int i = 0; i < MED_LAT; i++) ctr_pipe_reg[i] <= '0;
                end else begin
                    ctr_pipe_reg[0] <= {ctr_red, ctr_green, ctr_blue};
                    for (int i = 1; i < MED_LAT; i++) ctr_pipe_reg[i] <= ctr_pipe_reg[i-1];
                end
            end
            assign ctr_d = ctr_pipe_reg[MED_LAT-1];
        end else begin : g_ctr_direct
            assign ctr_d = {ctr_red, ctr_green, ctr_blue};
        end
    endgenerate

    logic [11:0] col_reg, row_reg, frame_rows;
    // A line ending on the same cycle as vs rise still counts toward the frame.
    assign frame_rows = (dv_fall && row_reg != CNT_MAX) ? row_reg + 12'd1 : row_reg;

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            col_reg <= '0;
            row_reg <= '0;
        end else begin
            if (dv_fall)                        col_reg <= '0;
            else if (pre_dv && col_reg != CNT_MAX) col_reg <= col_reg + 12'd1;
            if (vs_rise)                        row_reg <= '0;
            else if (dv_fall && row_reg != CNT_MAX) row_reg <= row_reg + 12'd1;
        end
    end

    state_t      state_reg, state_next;
    logic        armed_reg, armed_next;
    logic        len_valid_reg, len_valid_next;
    logic [11:0] line_len_reg, line_len_next;
    logic [11:0] h_active_reg, h_active_next;
    logic [11:0] v_active_reg, v_active_next;
    logic        err_event;
    logic        line_bad, frame_bad;

    // A saturated column count can never be a legal line length.
    assign line_bad  = dv_fall && (col_reg != h_active_reg || col_reg == CNT_MAX);
    assign frame_bad = vs_rise && (frame_rows != v_active_reg);

    always_comb begin
        state_next     = state_reg;
        armed_next     = armed_reg;
        len_valid_next = len_valid_reg;
        line_len_next  = line_len_reg;
        h_active_next  = h_active_reg;
        v_active_next  = v_active_reg;
        err_event      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (vs_rise) begin
                    state_next     = MEASURE;
                    armed_next     = 1'b1;
                    len_valid_next = 1'b0;
                end
            end
            MEASURE: begin
                if (vs_rise) begin
                    // Only a frame that started inside MEASURE is trusted.
                    if (armed_reg && (len_valid_reg || dv_fall)) begin
                        h_active_next = len_valid_reg ? line_len_reg : col_reg;
                        v_active_next = frame_rows;
                        state_next    = RUN;
                    end
                    armed_next     = 1'b1;
                    len_valid_next = 1'b0;
                end else if (dv_fall && armed_reg && !len_valid_reg) begin
                    line_len_next  = col_reg;
                    len_valid_next = 1'b1;
                end
            end
            RUN: begin
                if (line_bad || frame_bad) begin
                    err_event      = 1'b1;
                    state_next     = MEASURE;
                    armed_next     = vs_rise;
                    len_valid_next = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    logic filt_reg, bmode_reg;

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_reg     <= IDLE;
            armed_reg     <= 1'b0;
            len_valid_reg <= 1'b0;
            line_len_reg  <= '0;
            h_active_reg  <= '0;
            v_active_reg  <= '0;
            filt_reg      <= 1'b0;
            bmode_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            armed_reg     <= armed_next;
            len_valid_reg <= len_valid_next;
            line_len_reg  <= line_len_next;
            h_active_reg  <= h_active_next;
            v_active_reg  <= v_active_next;
            if (vs_rise) begin
                filt_reg  <= filt_en;
                bmode_reg <= border_mode;
            end
        end
    end

    assign locked   = (state_reg == RUN);
    assign h_active = h_active_reg;
    assign v_active = v_active_reg;

    logic is_border;
    assign is_border = ({1'b0, col_reg} < BORDER_W)
                    || ({1'b0, col_reg} + BORDER_W >= {1'b0, h_active_reg})
                    || ({1'b0, row_reg} < BORDER_W)
                    || ({1'b0, row_reg} + BORDER_W >= {1'b0, v_active_reg});

    logic [23:0] pix_reg, pix_next;

    always_comb begin
        pix_next = '0;
        if (!pre_dv)                    pix_next = '0;
        else if (!locked || !filt_reg)  pix_next = ctr_d;
        else if (is_border)             pix_next = bmode_reg ? 24'h0 : ctr_d;
        else                            pix_next = {med_red, med_green, med_blue};
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) pix_reg <= '0;
        else            pix_reg <= pix_next;
    end
    assign {tx_red, tx_green, tx_blue} = pix_reg;

`ifdef MEDIAN_CTRL_STATS_EN
    logic [15:0] frame_cnt_reg;
    logic [7:0]  err_cnt_reg;

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            frame_cnt_reg <= '0;
            err_cnt_reg   <= '0;
        end else begin
            if (vs_rise)                          frame_cnt_reg <= frame_cnt_reg + 16'd1;
            if (err_event && err_cnt_reg != 8'hFF) err_cnt_reg   <= err_cnt_reg + 8'd1;
        end
    end
    assign frame_cnt = frame_cnt_reg;
    assign err_cnt   = err_cnt_reg;
`else
    logic unused_err_event;
    assign unused_err_event = err_event;
    assign frame_cnt = '0;
    assign err_cnt   = '0;
`endif

endmodule
